mdu_sequencer: RTL



---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_iter_ctrl.sv | 97 +++++++++
 rtl/mdu_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU operation codes
// understood by the shared ALU, MDU operation encodings and FSM states.
package mdu_pkg;

  // Codes driven on AluOp towards the shared ALU
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  // The ALU is parked on the AND code whenever the MDU does not need it
  localparam logic [3:0] ALU_IDLE = ALU_AND;

  // MDU operation encodings on Op (bit 0 selects divide, bit 1 selects signed)
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // Sequencer states; FIXUP is only reachable in the signed build
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_ctrl.sv
// Iteration counter and FSM for the MDU. Runs WIDTH CALC cycles per
// accepted request, optionally one FIXUP cycle (build macro MDU_SIGNED_EN),
// then returns to IDLE with a one-cycle done strobe.
module mdu_iter_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic fixup_req_i,
  output logic accept_o,
  output logic calc_o,
  output logic last_iter_o,
  output logic fixup_o,
  output logic done_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             last_iter;

`ifndef MDU_SIGNED_EN
  // Unsigned-only build never takes the FIXUP path
  logic unused_fixup_req;
  assign unused_fixup_req = fixup_req_i;
`endif

  assign last_iter = (state_q == CALC) && (cnt_q == CNT_W'(WIDTH - 1));

  // State, counter and done-strobe registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state: accept in IDLE, count CALC iterations, finish after the last
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CALC;
          cnt_d   = '0;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
`ifdef MDU_SIGNED_EN
          if (fixup_req_i) begin
            state_d = FIXUP;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
      FIXUP: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decoded from the current state for the datapath
  always_comb begin
    accept_o    = (state_q == IDLE) && start_i;
    calc_o      = (state_q == CALC);
    last_iter_o = last_iter;
    fixup_o     = (state_q == FIXUP);
    busy_o      = (state_q != IDLE);
    done_o      = done_q;
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle HI/LO multiply/divide unit. Holds no adder of its own: each
// CALC cycle it drives the shared ALU (AluA/AluB/AluOp) and folds AluResult
// into HI/LO. Shift-add multiply and restoring divide, one bit per cycle.
// Build macro MDU_SIGNED_EN enables signed MULT/DIV with a FIXUP cycle.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [3:0]       AluOp,
  input  logic [WIDTH-1:0] AluResult,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, md_q, md_d;
  logic               is_div_q, is_div_d;
  logic               fix_q, fix_d;
  logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic               accept, calc, last_iter, fixup;
  logic [WIDTH-1:0]   opa, opb, rem_sh;
  logic               carry, ge;
  logic [2*WIDTH-1:0] pair_neg;
  logic [WIDTH-1:0]   alu_a, alu_b;
  logic [3:0]         alu_op;

`ifdef MDU_SIGNED_EN
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction
`else
  // Signedness bit has no meaning without the signed build
  logic unused_op1;
  assign unused_op1 = Op[1];
`endif

  mdu_iter_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (Start),
    .fixup_req_i(fix_q),
    .accept_o   (accept),
    .calc_o     (calc),
    .last_iter_o(last_iter),
    .fixup_o    (fixup),
    .done_o     (Done),
    .busy_o     (Busy)
  );

  // The counter alone decides termination; the datapath does not need it
  logic unused_last_iter;
  assign unused_last_iter = last_iter;

  // Datapath next-state: load on accept, one iteration per CALC, sign fixup
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    md_d     = md_q;
    is_div_d = is_div_q;
    fix_d    = fix_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = ALU_IDLE;
    opa      = A;
    opb      = B;
    carry    = 1'b0;
    rem_sh   = '0;
    ge       = 1'b0;
    pair_neg = '0;
    if (accept) begin
      is_div_d = Op[0];
      hi_d     = '0;
`ifdef MDU_SIGNED_EN
      fix_d = Op[1];
      if (Op[1]) begin
        opa      = abs_w(A);
        opb      = abs_w(B);
        // neg_lo covers quotient or whole product; neg_hi is the remainder sign
        neg_lo_d = A[WIDTH-1] ^ B[WIDTH-1];
        neg_hi_d = Op[0] ? A[WIDTH-1] : (A[WIDTH-1] ^ B[WIDTH-1]);
      end else begin
        neg_lo_d = 1'b0;
        neg_hi_d = 1'b0;
      end
`else
      fix_d    = 1'b0;
      neg_lo_d = 1'b0;
      neg_hi_d = 1'b0;
`endif
      if (Op[0]) begin
        lo_d = opa;
        md_d = opb;
      end else begin
        lo_d = opb;
        md_d = opa;
      end
    end else if (calc) begin
      if (!is_div_q) begin
        alu_a  = hi_q;
        alu_b  = md_q;
        alu_op = ALU_ADD;
        // Carry out of the external adder recovered by wrap-around test
        carry  = (AluResult < hi_q);
        if (lo_q[0]) begin
          hi_d = {carry, AluResult[WIDTH-1:1]};
          lo_d = {AluResult[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[WIDTH-1:1]};
          lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
      end else begin
        rem_sh = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        alu_a  = rem_sh;
        alu_b  = md_q;
        alu_op = ALU_SUB;
        // The bit shifted out of HI makes the partial remainder exceed D
        ge     = hi_q[WIDTH-1] | (rem_sh >= md_q);
        hi_d   = ge ? AluResult : rem_sh;
        lo_d   = {lo_q[WIDTH-2:0], ge};
      end
    end else if (fixup) begin
      pair_neg = -{hi_q, lo_q};
      if (!is_div_q) begin
        if (neg_lo_q) begin
          hi_d = pair_neg[2*WIDTH-1:WIDTH];
          lo_d = pair_neg[WIDTH-1:0];
        end
      end else begin
        if (neg_lo_q) lo_d = -lo_q;
        if (neg_hi_q) hi_d = -hi_q;
      end
    end
  end

  // HI/LO and operation flags; reset aborts any operation and clears HI/LO
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      fix_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      fix_q    <= fix_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

  // Multiplicand / divisor register, only meaningful while busy
  always_ff @(posedge clk) begin
    md_q <= md_d;
  end

  assign AluA  = alu_a;
  assign AluB  = alu_b;
  assign AluOp = alu_op;
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule
